// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the rst_seq reset sequencer.
//   state_e    - sequencer FSM state encoding (also exported on state_o)
//   LOSS_CNT_W - width of the optional lock-loss counter (RST_SEQ_LOSS_CNT_EN)
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_e;

    localparam int unsigned LOSS_CNT_W = 8;

endpackage : rst_seq_pkg

// File: rtl/rst_seq_bit_sync.sv
// rst_seq_bit_sync: SYNC_STAGES-deep flop chain that brings a single
// asynchronous bit into the clk_i domain. All stages reset to 0.
//   clk_i    in  system clock
//   rst_n_i  in  asynchronous active-low reset
//   d_i      in  asynchronous input bit
//   q_o      out synchronised bit (last stage)
module rst_seq_bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule : rst_seq_bit_sync

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer. Qualifies a synchronised PLL-lock signal for
// LOCK_FILT cycles, then releases rst_n_o[0..N_RST-1] one at a time,
// STAGE_DLY cycles apart. Lock loss or a software reset re-asserts all
// outputs; a software reset additionally holds them for HOLD_CYC cycles.
//   clk_i      in  system clock
//   rst_n_i    in  asynchronous active-low reset (pre-synchronised release)
//   lock_i     in  PLL lock, asynchronous to clk_i
//   sw_rst_i   in  software reset request, synchronous
//   rst_n_o    out sequenced active-low resets, bit 0 first (flop outputs)
//   done_o     out all outputs released (state RUN)
//   state_o    out FSM state for debug
//   loss_cnt_o out saturating lock-loss event count, only when the macro
//                  RST_SEQ_LOSS_CNT_EN is defined
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_RST       = 6,
    parameter int unsigned STAGE_DLY   = 16,
    parameter int unsigned LOCK_FILT   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             lock_i,
    input  logic             sw_rst_i,
    output logic [N_RST-1:0] rst_n_o,
    output logic             done_o,
    output logic [1:0]       state_o
`ifdef RST_SEQ_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
`endif
);

    localparam int unsigned LF_W   = $clog2(LOCK_FILT) + 1;
    localparam int unsigned DLY_W  = $clog2(STAGE_DLY) + 1;
    localparam int unsigned STG_W  = $clog2(N_RST) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC) + 1;

    localparam logic [LF_W-1:0]   LF_LAST   = LF_W'(LOCK_FILT - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_RST - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic lock_s;

    state_e             state_q, state_d;
    logic [N_RST-1:0]   rst_q,   rst_d;
    logic               done_q,  done_d;
    logic [LF_W-1:0]    lf_q,    lf_d;
    logic [DLY_W-1:0]   dly_q,   dly_d;
    logic [STG_W-1:0]   stg_q,   stg_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic [STG_W-1:0]   stg_nxt;

    rst_seq_bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .d_i    (lock_i),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        done_d  = done_q;
        lf_d    = lf_q;
        dly_d   = dly_q;
        stg_d   = stg_q;
        hold_d  = hold_q;
        stg_nxt = stg_q + 1'b1;

        unique case (state_q)
            WAIT_LOCK: begin
                rst_d  = '0;
                done_d = 1'b0;
                dly_d  = '0;
                stg_d  = '0;
                hold_d = '0;
                // A software reset here only restarts the lock filter;
                // outputs are already asserted so HOLD adds nothing.
                if (sw_rst_i || !lock_s) begin
                    lf_d = '0;
                end else if (lf_q == LF_LAST) begin
                    lf_d     = '0;
                    rst_d[0] = 1'b1;
                    if (N_RST == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    lf_d = lf_q + 1'b1;
                end
            end

            RELEASE, RUN: begin
                if (sw_rst_i) begin
                    state_d = HOLD;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    lf_d    = '0;
                    dly_d   = '0;
                    stg_d   = '0;
                    hold_d  = '0;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    lf_d    = '0;
                    dly_d   = '0;
                    stg_d   = '0;
                    hold_d  = '0;
                end else if (state_q == RELEASE) begin
                    if (dly_q == DLY_LAST) begin
                        dly_d = '0;
                        stg_d = stg_nxt;
                        // Bits are released strictly in order, so only the
                        // bit selected by the new stage index is set.
                        for (int unsigned i = 0; i < N_RST; i++) begin
                            if (stg_nxt == STG_W'(i)) begin
                                rst_d[i] = 1'b1;
                            end
                        end
                        if (stg_nxt == STG_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
            end

            HOLD: begin
                rst_d  = '0;
                done_d = 1'b0;
                lf_d   = '0;
                // lock_s is deliberately ignored while holding.
                if (sw_rst_i) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = WAIT_LOCK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '0;
                done_d  = 1'b0;
                lf_d    = '0;
                dly_d   = '0;
                stg_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WAIT_LOCK;
            rst_q   <= '0;
            done_q  <= 1'b0;
            lf_q    <= '0;
            dly_q   <= '0;
            stg_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            lf_q    <= lf_d;
            dly_q   <= dly_d;
            stg_q   <= stg_d;
            hold_q  <= hold_d;
        end
    end

    assign rst_n_o = rst_q;
    assign done_o  = done_q;
    assign state_o = state_q;

`ifdef RST_SEQ_LOSS_CNT_EN
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    // Counts only lock-triggered exits from RELEASE/RUN; a simultaneous
    // software reset takes priority and is not a loss event.
    always_comb begin
        lock_lost = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s && !sw_rst_i;
        loss_d    = loss_q;
        if (lock_lost && (loss_q != '1)) begin
            loss_d = loss_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt_o = loss_q;
`endif

endmodule : rst_seq
